// File: rtl/sram_1rw1r_bm_if.sv
// sram_1rw1r_bm_if: bus bundle for the 1RW + 1R SRAM model.
// The master side issues requests on port 0 (read/write) and port 1 (read only)
// and observes the read data, the read-valid strobes and the clear-sweep busy flag.
interface sram_1rw1r_bm_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8
);
  logic                   busy;
  logic                   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  dout0;
  logic                   dout0_vld;
  logic                   csb1;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [DATA_WIDTH-1:0]  dout1;
  logic                   dout1_vld;

  modport master (
    input  busy, dout0, dout0_vld, dout1, dout1_vld,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output busy, dout0, dout0_vld, dout1, dout1_vld,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/sram_1rw1r_bm.sv
// sram_1rw1r_bm: synchronous SRAM model, port 0 read/write with byte mask,
// port 1 read only, READ_LATENCY of 1 or 2 edges, read-valid strobes and an
// optional zero-clear sweep after reset (busy high while it runs).
// Same-address port 0 write / port 1 read returns the old word by default;
// defining SRAM_WR_BYPASS_EN makes port 1 return the merged (written) word.
module sram_1rw1r_bm #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int WMASK_WIDTH    = DATA_WIDTH / 8
) (
  input logic            clk0,
  input logic            rst0,
  sram_1rw1r_bm_if.slave bus
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic                   busy_q;
  logic [ADDR_WIDTH-1:0]  clr_addr;
  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

  logic                   wr_en;
  logic                   rd0_en;
  logic                   rd1_en;
  logic [DATA_WIDTH-1:0]  rd1_word;

  logic                   rd0_v1;
  logic                   rd1_v1;
  logic [DATA_WIDTH-1:0]  rd0_d1;
  logic [DATA_WIDTH-1:0]  rd1_d1;

  // User requests only take effect in RUN and never on a reset edge.
  assign wr_en  = (state == RUN) && !rst0 && !bus.csb0 && !bus.web0;
  assign rd0_en = (state == RUN) && !rst0 && !bus.csb0 &&  bus.web0;
  assign rd1_en = (state == RUN) && !rst0 && !bus.csb1;

  assign bus.busy = busy_q;

  // Port 1 read word: old contents, optionally merged with a same-edge port 0 write.
  always_comb begin
    rd1_word = mem[bus.addr1];
`ifdef SRAM_WR_BYPASS_EN
    if (wr_en && (bus.addr0 == bus.addr1)) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (bus.wmask0[i]) rd1_word[8*i +: 8] = bus.din0[8*i +: 8];
      end
    end
`endif
  end

  // Sweep FSM: walk every address once after reset, then hand over to RUN.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      clr_addr <= '0;
      if (CLEAR_ON_RESET != 0) begin
        state  <= CLEAR;
        busy_q <= 1'b1;
      end else begin
        state  <= RUN;
        busy_q <= 1'b0;
      end
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (&clr_addr) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  // Storage array: sweep zero-fill or masked port 0 write; not touched by reset itself.
  always_ff @(posedge clk0) begin
    if (!rst0 && (state == CLEAR)) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (bus.wmask0[i]) mem[bus.addr0][8*i +: 8] <= bus.din0[8*i +: 8];
      end
    end
  end

  // First read stage: capture array data on a read, hold it otherwise.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd0_v1 <= 1'b0;
      rd1_v1 <= 1'b0;
      rd0_d1 <= '0;
      rd1_d1 <= '0;
    end else begin
      rd0_v1 <= rd0_en;
      rd1_v1 <= rd1_en;
      if (rd0_en) rd0_d1 <= mem[bus.addr0];
      if (rd1_en) rd1_d1 <= rd1_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd0_v2;
    logic                  rd1_v2;
    logic [DATA_WIDTH-1:0] rd0_d2;
    logic [DATA_WIDTH-1:0] rd1_d2;

    // Second read stage: delay data and strobe by one more edge.
    always_ff @(posedge clk0) begin
      if (rst0) begin
        rd0_v2 <= 1'b0;
        rd1_v2 <= 1'b0;
        rd0_d2 <= '0;
        rd1_d2 <= '0;
      end else begin
        rd0_v2 <= rd0_v1;
        rd1_v2 <= rd1_v1;
        if (rd0_v1) rd0_d2 <= rd0_d1;
        if (rd1_v1) rd1_d2 <= rd1_d1;
      end
    end

    assign bus.dout0     = rd0_d2;
    assign bus.dout0_vld = rd0_v2;
    assign bus.dout1     = rd1_d2;
    assign bus.dout1_vld = rd1_v2;
  end else begin : g_lat1
    assign bus.dout0     = rd0_d1;
    assign bus.dout0_vld = rd0_v1;
    assign bus.dout1     = rd1_d1;
    assign bus.dout1_vld = rd1_v1;
  end

endmodule

// File: tb/tb_sram_1rw1r_bm.sv
// tb_sram_1rw1r_bm: three small instances (16 words) share one stimulus stream:
//   dut 0: READ_LATENCY=1, CLEAR_ON_RESET=1
//   dut 1: READ_LATENCY=2, CLEAR_ON_RESET=1
//   dut 2: READ_LATENCY=2, CLEAR_ON_RESET=0
// A word-level reference model predicts every output each cycle; directed
// sequences and a byte-mask vector table add fixed expected values.
module tb_sram_1rw1r_bm;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{1, 2, 2};
  localparam int CLR [NDUT] = '{1, 1, 0};

`ifdef SRAM_WR_BYPASS_EN
  localparam logic [31:0] EXP_COLLIDE = 32'h1234FFFF;
`else
  localparam logic [31:0] EXP_COLLIDE = 32'h12345678;
`endif

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          csb0 = 1'b1;
  logic          web0 = 1'b1;
  logic [3:0]    wmask0 = '0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] din0 = '0;
  logic          csb1 = 1'b1;
  logic [AW-1:0] addr1 = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_bm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  sram_1rw1r_bm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();
  sram_1rw1r_bm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_c ();

  sram_1rw1r_bm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
    u_dut_a (.clk0(clk0), .rst0(rst0), .bus(if_a.slave));
  sram_1rw1r_bm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1))
    u_dut_b (.clk0(clk0), .rst0(rst0), .bus(if_b.slave));
  sram_1rw1r_bm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(0))
    u_dut_c (.clk0(clk0), .rst0(rst0), .bus(if_c.slave));

  assign if_a.csb0 = csb0;  assign if_b.csb0 = csb0;  assign if_c.csb0 = csb0;
  assign if_a.web0 = web0;  assign if_b.web0 = web0;  assign if_c.web0 = web0;
  assign if_a.wmask0 = wmask0;  assign if_b.wmask0 = wmask0;  assign if_c.wmask0 = wmask0;
  assign if_a.addr0 = addr0;  assign if_b.addr0 = addr0;  assign if_c.addr0 = addr0;
  assign if_a.din0 = din0;  assign if_b.din0 = din0;  assign if_c.din0 = din0;
  assign if_a.csb1 = csb1;  assign if_b.csb1 = csb1;  assign if_c.csb1 = csb1;
  assign if_a.addr1 = addr1;  assign if_b.addr1 = addr1;  assign if_c.addr1 = addr1;

  logic [DW-1:0] act_d0 [NDUT];
  logic [DW-1:0] act_d1 [NDUT];
  logic          act_v0 [NDUT];
  logic          act_v1 [NDUT];
  logic          act_busy [NDUT];

  assign act_d0[0] = if_a.dout0;  assign act_d0[1] = if_b.dout0;  assign act_d0[2] = if_c.dout0;
  assign act_d1[0] = if_a.dout1;  assign act_d1[1] = if_b.dout1;  assign act_d1[2] = if_c.dout1;
  assign act_v0[0] = if_a.dout0_vld;  assign act_v0[1] = if_b.dout0_vld;  assign act_v0[2] = if_c.dout0_vld;
  assign act_v1[0] = if_a.dout1_vld;  assign act_v1[1] = if_b.dout1_vld;  assign act_v1[2] = if_c.dout1_vld;
  assign act_busy[0] = if_a.busy;  assign act_busy[1] = if_b.busy;  assign act_busy[2] = if_c.busy;

  // Compare one observed value with its expected value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive every request input for the next clock edge.
  task automatic applyStimulus(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d,
                               input logic c1, input logic [AW-1:0] a1);
    rst0 = r;  csb0 = c0;  web0 = w0;  wmask0 = m;
    addr0 = a0;  din0 = d;  csb1 = c1;  addr1 = a1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0);
  endtask

  task automatic tick();
    @(negedge clk0);
  endtask

  // Bounded wait for both clearing instances to finish their sweep.
  task automatic waitSweep();
    int n;
    n = 0;
    idle();
    while ((if_a.busy || if_b.busy) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("sweep_done", 32'(if_a.busy | if_b.busy), 32'h0);
  endtask

  // ------------------------------------------------------------------
  // Reference model: word array per instance, busy as "edges left to clear",
  // reads queued with the cycle number at which they become visible.
  // ------------------------------------------------------------------
  typedef struct {
    int          dut;
    int          port;
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [DW-1:0] m_mem [NDUT][16];
  int            m_busy_left [NDUT];
  logic [DW-1:0] exp_d0 [NDUT];
  logic [DW-1:0] exp_d1 [NDUT];
  logic          exp_v0 [NDUT];
  logic          exp_v1 [NDUT];
  logic          exp_busy [NDUT];
  rd_t           pend [$];
  rd_t           keep [$];
  int            cyc = 0;
  logic [DW-1:0] old0, old1, bm;

  function automatic logic [31:0] byteMask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
      m_busy_left[k] = 0;
    end
  end

  always @(posedge clk0) begin
    cyc = cyc + 1;
    if (rst0) pend.delete();
    for (int k = 0; k < NDUT; k++) begin
      exp_v0[k] = 1'b0;
      exp_v1[k] = 1'b0;
      if (rst0) begin
        m_busy_left[k] = (CLR[k] != 0) ? 16 : 0;
        exp_d0[k] = '0;
        exp_d1[k] = '0;
      end else if (m_busy_left[k] > 0) begin
        m_mem[k][16 - m_busy_left[k]] = '0;
        m_busy_left[k] = m_busy_left[k] - 1;
      end else begin
        old0 = m_mem[k][addr0];
        old1 = m_mem[k][addr1];
        bm   = byteMask(wmask0);
        if (!csb0 && !web0) begin
          m_mem[k][addr0] = (old0 & ~bm) | (din0 & bm);
`ifdef SRAM_WR_BYPASS_EN
          if (addr1 == addr0) old1 = m_mem[k][addr0];
`endif
        end
        if (!csb0 && web0) pend.push_back('{k, 0, cyc + LAT[k] - 1, old0});
        if (!csb1) pend.push_back('{k, 1, cyc + LAT[k] - 1, old1});
      end
      exp_busy[k] = (m_busy_left[k] > 0);
    end
    keep.delete();
    foreach (pend[j]) begin
      if (pend[j].due == cyc) begin
        if (pend[j].port == 0) begin
          exp_d0[pend[j].dut] = pend[j].data;
          exp_v0[pend[j].dut] = 1'b1;
        end else begin
          exp_d1[pend[j].dut] = pend[j].data;
          exp_v1[pend[j].dut] = 1'b1;
        end
      end else begin
        keep.push_back(pend[j]);
      end
    end
    pend = keep;
  end

  // Every cycle, compare all outputs of all instances against the model.
  always @(negedge clk0) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("dut%0d.busy", k), 32'(act_busy[k]), 32'(exp_busy[k]));
        checkOutput($sformatf("dut%0d.dout0_vld", k), 32'(act_v0[k]), 32'(exp_v0[k]));
        checkOutput($sformatf("dut%0d.dout1_vld", k), 32'(act_v1[k]), 32'(exp_v1[k]));
        checkOutput($sformatf("dut%0d.dout0", k), act_d0[k], exp_d0[k]);
        checkOutput($sformatf("dut%0d.dout1", k), act_d1[k], exp_d1[k]);
      end
    end
  end

  // Byte-mask vectors: full write, masked overwrite, then read back.
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data_a;
    logic [3:0]    mask_a;
    logic [31:0]   data_b;
    logic [3:0]    mask_b;
    logic [31:0]   expect_word;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;

    vecs[0] = '{4'd3,  32'hAABBCCDD, 4'hF, 32'h11223344, 4'b0101, 32'hAA22CC44};
    vecs[1] = '{4'd9,  32'h01234567, 4'hF, 32'h89ABCDEF, 4'b1010, 32'h8923CD67};
    vecs[2] = '{4'd12, 32'hFFFFFFFF, 4'hF, 32'h00000000, 4'b0000, 32'hFFFFFFFF};
    vecs[3] = '{4'd0,  32'h00000000, 4'hF, 32'hDEADBEEF, 4'b1000, 32'hDE000000};
    vecs[4] = '{4'd15, 32'h12345678, 4'hF, 32'hA5A5A5A5, 4'b0110, 32'h12A5A578};

    // Reset for two edges, then the clear sweep with a write attempted while busy.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0);
    tick();
    chk_en = 1'b1;
    tick();
    checkOutput("busy_at_reset_a", 32'(if_a.busy), 32'h1);
    checkOutput("busy_at_reset_c", 32'(if_c.busy), 32'h0);
    n = 0;
    do begin
      if (n == 2) applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 4'd0, 32'hCAFEF00D, 1'b1, '0);
      else idle();
      tick();
      n++;
    end while (if_a.busy && n < 40);
    checkOutput("sweep_len", 32'(n), 32'd16);

    // Every word of a cleared instance reads back as zero.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, '0, '0, 1'b0, AW'(i));
      tick();
      checkOutput($sformatf("clear_word_%0d", i), if_a.dout1, 32'h0);
    end
    idle();
    tick();
    tick();

    // Preload word i with value i everywhere.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, AW'(i), 32'(i), 1'b1, '0);
      tick();
    end

    // Latency-2 pipelined port 1 reads of addresses 1, 2, 3.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, '0, '0, 1'b0, 4'd1);
    tick();
    checkOutput("lat2_vld_early", 32'(if_b.dout1_vld), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, '0, '0, 1'b0, 4'd2);
    tick();
    checkOutput("lat2_vld_1", 32'(if_b.dout1_vld), 32'h1);
    checkOutput("lat2_data_1", if_b.dout1, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, '0, '0, 1'b0, 4'd3);
    tick();
    checkOutput("lat2_vld_2", 32'(if_b.dout1_vld), 32'h1);
    checkOutput("lat2_data_2", if_b.dout1, 32'h2);
    idle();
    tick();
    checkOutput("lat2_vld_3", 32'(if_b.dout1_vld), 32'h1);
    checkOutput("lat2_data_3", if_b.dout1, 32'h3);
    tick();
    checkOutput("lat2_vld_end", 32'(if_b.dout1_vld), 32'h0);
    checkOutput("lat2_hold", if_b.dout1, 32'h3);

    // Byte-mask vector table.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[v].mask_a, vecs[v].addr, vecs[v].data_a, 1'b1, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[v].mask_b, vecs[v].addr, vecs[v].data_b, 1'b1, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, vecs[v].addr, '0, 1'b1, '0);
      tick();
      checkOutput($sformatf("bmask_v%0d_lat1", v), if_a.dout0, vecs[v].expect_word);
      idle();
      tick();
      checkOutput($sformatf("bmask_v%0d_lat2", v), if_c.dout0, vecs[v].expect_word);
    end

    // Same-address collision: port 0 masked write with port 1 read of address 5.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 4'd5, 32'h12345678, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd5);
    tick();
    checkOutput("collide_lat1", if_a.dout1, EXP_COLLIDE);
    idle();
    tick();
    checkOutput("collide_lat2", if_b.dout1, EXP_COLLIDE);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd5, '0, 1'b1, '0);
    tick();
    checkOutput("collide_after_lat1", if_a.dout0, 32'h1234FFFF);
    idle();
    tick();
    checkOutput("collide_after_lat2", if_b.dout0, 32'h1234FFFF);

    // Reset lands while a latency-2 read is in flight.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd1, '0, 1'b1, '0);
    tick();
    checkOutput("midrd_vld_pre", 32'(if_b.dout0_vld), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0);
    tick();
    checkOutput("midrd_vld", 32'(if_b.dout0_vld), 32'h0);
    checkOutput("midrd_dout0", if_b.dout0, 32'h0);
    checkOutput("midrd_busy", 32'(if_b.busy), 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("midrd_vld_after_%0d", i), 32'(if_b.dout0_vld), 32'h0);
    end
    waitSweep();

    // Contents survive reset when the clear sweep is disabled.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, '0, '0, 1'b1, '0);
    tick();
    checkOutput("noclr_busy", 32'(if_c.busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'd7, '0, 1'b1, '0);
    tick();
    idle();
    tick();
    checkOutput("noclr_vld", 32'(if_c.dout0_vld), 32'h1);
    checkOutput("noclr_data", if_c.dout0, 32'hDEADBEEF);
    waitSweep();

    // Random traffic with frequent collisions and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      a0 = AW'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), a0, $urandom,
                    ($urandom_range(0, 2) == 0), a1);
      tick();
    end
    idle();
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_bm.md
Name: sram_1rw1r_bm

Overview:
- Parametrised synchronous SRAM model; next generation of the team's single-port 32-bit OpenRAM-style model.
- Port 0: read/write with per-byte write mask. Port 1: read-only.
- Adds configurable read latency, read-valid strobes, defined port collision rule, and a reset-driven zero-clear sweep with a busy flag.
- Drop-in for scratchpads and register-file banks in the accelerator memory subsystem.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, address bits; RAM_DEPTH = 1 << ADDR_WIDTH.
- READ_LATENCY, 1, clock edges from sampled read to dout/vld; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset via sweep FSM; 0 = contents untouched by reset.
- WMASK_WIDTH, DATA_WIDTH/8, derived; byte-enable count.

Ports:
- clk0 input 1: single clock, all logic on its rising edge.
- rst0 input 1: synchronous, active-high reset.
- busy output 1: high while the clear sweep runs; requests ignored.
- csb0 input 1: port 0 chip select, active low.
- web0 input 1: port 0 write enable, active low (0 = write, 1 = read).
- wmask0 input WMASK_WIDTH: port 0 byte enables; bit i covers din0[8i+7:8i].
- addr0 input ADDR_WIDTH: port 0 address.
- din0 input DATA_WIDTH: port 0 write data.
- dout0 output DATA_WIDTH: port 0 read data.
- dout0_vld output 1: one-cycle strobe, dout0 carries new read data.
- csb1 input 1: port 1 chip select, active low (read only).
- addr1 input ADDR_WIDTH: port 1 address.
- dout1 output DATA_WIDTH: port 1 read data.
- dout1_vld output 1: one-cycle strobe for dout1.

Behaviour:
- Reset (rst0=1 at an edge): dout0=0, dout1=0, dout0_vld=0, dout1_vld=0, all read pipeline stages flushed, sweep counter=0.
- busy reset value: 1 if CLEAR_ON_RESET=1, else 0.
- Reset asserted mid-operation (including mid-sweep) has the same effect. In-flight reads are dropped with no vld. The sweep restarts at address 0.
- FSM states:
  - CLEAR: entered from reset when CLEAR_ON_RESET=1. Each edge with rst0=0 writes 0 to mem[counter] and increments counter. At counter=RAM_DEPTH-1 the write occurs, busy goes 0 at that same edge, and the FSM moves to RUN. Sweep length is exactly RAM_DEPTH edges after reset deassertion.
  - RUN: normal access. Entered directly from reset when CLEAR_ON_RESET=0.
- While busy=1: csb0/csb1 ignored; no user writes; no vld.
- Port 0 write (RUN, csb0=0, web0=0): at the edge, mem[addr0] byte i <= din0 byte i where wmask0[i]=1; other bytes unchanged.
  - wmask0=0 is a legal no-op.
  - No read strobe; dout0 holds its value.
- Port 0 read (csb0=0, web0=1) or port 1 read (csb1=0) sampled at edge N:
  - READ_LATENCY=1: data on dout after edge N, vld high for the following cycle.
  - READ_LATENCY=2: data and vld appear one edge later.
  - Back-to-back reads every cycle are fully pipelined.
- dout0/dout1 hold the last read value until the next read completes. They are never cleared except by reset.
- Collision (port 0 write and port 1 read, same address, same edge): port 1 returns the pre-write (old) word. This is read-before-write, unless the optional feature below is enabled.
- Different-address simultaneous access: fully independent.
- Memory contents are not affected by reset when CLEAR_ON_RESET=0. The simulation initial value is 0 for every word.
- Address wrap: none; every address 0..RAM_DEPTH-1 is valid; no out-of-range handling is needed.

Optional Feature:
- Macro SRAM_WR_BYPASS_EN.
- Defined: on a same-address collision, port 1 returns the merged word, with bytes where wmask0=1 taken from din0 and all other bytes old. Latency and vld timing are unchanged.
- Undefined: old-data (read-before-write) collision behaviour as in Behaviour.

Test Plan:
- Clear sweep, ADDR_WIDTH=4, CLEAR_ON_RESET=1: hold rst0 for 2 cycles, release -> busy stays 1 for exactly 16 edges then 0. Port 1 reads of addresses 0..15 return 0x00000000. A port 0 write issued while busy is ignored.
- Byte mask: write 0xAABBCCDD to addr 3 with wmask0=4'hF, then 0x11223344 with wmask0=4'b0101 -> port 0 read of addr 3 returns 0xAA22CC44.
- Latency: READ_LATENCY=2; port 1 reads of addr 1,2,3 on consecutive edges (preloaded 0x1,0x2,0x3) -> dout1_vld high for 3 consecutive cycles beginning two edges after the first request, with data 0x1,0x2,0x3. dout1 holds 0x3 afterwards.
- Collision: mem[5]=0x12345678; same edge port 0 writes 0xFFFFFFFF (wmask0=4'b0011) and port 1 reads addr 5.
  - Without SRAM_WR_BYPASS_EN -> 0x12345678.
  - With SRAM_WR_BYPASS_EN -> 0x1234FFFF.
  - A later read returns 0x1234FFFF in both builds.
- Reset mid-read: issue a port 0 read (READ_LATENCY=2), assert rst0 on the next edge -> dout0_vld never rises, dout0=0, busy=1 (CLEAR_ON_RESET=1).
- CLEAR_ON_RESET=0: write 0xDEADBEEF to addr 7, pulse rst0 -> busy=0, and a read of addr 7 still returns 0xDEADBEEF.
